cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/fcpu_pkg.sv | 13 +
 rtl/cdb_arbiter_rr_pick.sv | 38 +++
 rtl/cdb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/fcpu_pkg.sv
// Shared CPU-wide widths and the common data bus payload type.
package fcpu_pkg;

  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [DATA_W-1:0]   data;
  } cdb_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating priority picker: rotate requests by ptr, take the lowest set bit,
// then map the offset back to an absolute unit index.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    any = 1'b0;
    off = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        off = IDX_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_L) sum = sum - N_L;
    idx = sum[IDX_W-1:0];
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: zero-latency grant to one functional unit and a
// registered one-cycle broadcast of the granted result.
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter int  N_UNITS = 3,
  parameter int  RR_MODE = 1,
  parameter int  CNT_W   = 16,
  localparam int GNT_W   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [N_UNITS-1:0] units_cdb_valid,
  input  cdb_t [N_UNITS-1:0] units_cdb,
  output logic [N_UNITS-1:0] units_cdb_ready,
  input  logic               flush,
  output logic [CDB_W-1:0]   cdb,
  output logic               cdb_valid,
  output logic [GNT_W-1:0]   cdb_src,
  output logic [CNT_W-1:0]   bcast_count
);

  logic [N_UNITS-1:0] req_p0;
  logic [N_UNITS-1:0] gnt_p0;
  logic [GNT_W-1:0]   idx_p0;
  logic               xfer_p0;
  logic [GNT_W-1:0]   ptr;
  logic [GNT_W-1:0]   pick_ptr;
  cdb_t               sel_p0;

  cdb_t               cdb_p1;
  logic               vld_p1;
  logic [GNT_W-1:0]   src_p1;
  logic [CNT_W-1:0]   cnt_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [GNT_W-1:0] ptr_after(input logic [GNT_W-1:0] i);
    return (i == GNT_W'(N_UNITS - 1)) ? '0 : i + GNT_W'(1);
  endfunction

  // Stage p0: combinational request gating, pick and payload select.
  // Reset and flush both mask requests so no grant can leak out.
  assign req_p0   = (nrst && !flush) ? units_cdb_valid : '0;
  assign pick_ptr = (RR_MODE != 0) ? ptr : '0;

  rr_pick #(
    .N     (N_UNITS),
    .IDX_W (GNT_W)
  ) u_pick (
    .req (req_p0),
    .ptr (pick_ptr),
    .gnt (gnt_p0),
    .idx (idx_p0),
    .any (xfer_p0)
  );

  assign units_cdb_ready = gnt_p0;

  always_comb begin
    sel_p0 = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (gnt_p0[i]) sel_p0 = units_cdb[i];
    end
  end

  // Stage p1: registered broadcast, round-robin pointer and statistics.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cdb_p1 <= '0;
      vld_p1 <= 1'b0;
      src_p1 <= '0;
      cnt_p1 <= '0;
      ptr    <= '0;
    end else begin
      vld_p1 <= xfer_p0;
      cdb_p1 <= sel_p0;
      src_p1 <= xfer_p0 ? idx_p0 : '0;
      if (xfer_p0) begin
        cnt_p1 <= sat_inc(cnt_p1);
        ptr    <= ptr_after(idx_p0);
      end
    end
  end

  assign cdb         = cdb_p1;
  assign cdb_valid   = vld_p1;
  assign cdb_src     = src_p1;
  assign bcast_count = cnt_p1;

endmodule
